// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared definitions for the memory-mapped seven-segment scanner: register offsets,
// control bit positions and scan FSM state encodings.
package seg7_scan_ctrl_pkg;

  localparam logic [31:0] VALUE_OFS   = 32'h0;
  localparam logic [31:0] CTRL_OFS    = 32'h4;

  localparam int          CTRL_EN     = 0;
  localparam int          CTRL_LZS    = 1;
  localparam int          CTRL_DP_LSB = 4;
  // CTRL bits [3:2] have no storage and always read back as zero.
  localparam logic [7:0]  CTRL_WMASK  = 8'hF3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seg7_scan_ctrl_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph, bit order {g,f,e,d,c,b,a}.
module hex_to_seg7 (
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = 7'h7F;
    case (nibble)
      4'h0: seg_n = 7'h40;
      4'h1: seg_n = 7'h79;
      4'h2: seg_n = 7'h24;
      4'h3: seg_n = 7'h30;
      4'h4: seg_n = 7'h19;
      4'h5: seg_n = 7'h12;
      4'h6: seg_n = 7'h02;
      4'h7: seg_n = 7'h78;
      4'h8: seg_n = 7'h00;
      4'h9: seg_n = 7'h10;
      4'hA: seg_n = 7'h08;
      4'hB: seg_n = 7'h03;
      4'hC: seg_n = 7'h46;
      4'hD: seg_n = 7'h21;
      4'hE: seg_n = 7'h06;
      4'hF: seg_n = 7'h0E;
      default: seg_n = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit seven-segment scanner: VALUE/CTRL registers on the MEM-stage bus,
// a SHOW/BLANK scan FSM over a latched shadow copy, and registered display outputs.
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h40000014,
  parameter int          REFRESH_DIV  = 50000,
  parameter int          BLANK_CYCLES = 500,
  parameter int          CNT_BITS     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] Read_data,
  output logic [7:0]  BCDData,
  output logic [3:0]  an
);

  localparam logic [CNT_BITS-1:0] SHOW_LAST  = CNT_BITS'(REFRESH_DIV - 1);
  localparam logic [CNT_BITS-1:0] BLANK_LAST = CNT_BITS'(BLANK_CYCLES - 1);

  logic [15:0]         value_reg;
  logic [7:0]          ctrl_reg;
  logic [15:0]         shadow_reg, shadow_next;
  logic [1:0]          idx_reg, idx_next;
  logic [CNT_BITS-1:0] cnt_reg, cnt_next;
  scan_state_e         state_reg, state_next;
  logic [3:0]          an_reg, an_next;
  logic [7:0]          seg_reg, seg_next;

  logic                hit_value, hit_ctrl;
  logic                en, lzs;
  logic [3:0]          dp_mask;
  logic [3:0]          cur_nibble;
  logic [6:0]          cur_glyph_n;
  logic                digit_dark;
  wire                 unused_write_bits = &{1'b0, Write_data[31:16]};

  assign hit_value = (Address == BASE_ADDR + VALUE_OFS);
  assign hit_ctrl  = (Address == BASE_ADDR + CTRL_OFS);
  assign en        = ctrl_reg[CTRL_EN];
  assign lzs       = ctrl_reg[CTRL_LZS];
  assign dp_mask   = ctrl_reg[CTRL_DP_LSB +: 4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_reg <= 16'h0;
      ctrl_reg  <= 8'h0;
    end else if (MemWrite) begin
      if (hit_value) value_reg <= Write_data[15:0];
      if (hit_ctrl)  ctrl_reg  <= Write_data[7:0] & CTRL_WMASK;
    end
  end

  always_comb begin
    Read_data = 32'h0;
    if (MemRead && hit_value)     Read_data = {16'h0, value_reg};
    else if (MemRead && hit_ctrl) Read_data = {24'h0, ctrl_reg};
  end

  assign cur_nibble = shadow_reg[{idx_reg, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (cur_nibble),
    .seg_n  (cur_glyph_n)
  );

  // A leading digit goes dark only when it and every more-significant nibble are zero.
  assign digit_dark = lzs && (idx_reg != 2'd0) &&
                      ((shadow_reg >> {idx_reg, 2'b00}) == 16'h0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      idx_reg    <= 2'd0;
      cnt_reg    <= '0;
      shadow_reg <= 16'h0;
      an_reg     <= 4'hF;
      seg_reg    <= 8'hFF;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      cnt_reg    <= cnt_next;
      shadow_reg <= shadow_next;
      an_reg     <= an_next;
      seg_reg    <= seg_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    cnt_next    = cnt_reg;
    shadow_next = shadow_reg;
    an_next     = 4'hF;
    seg_next    = 8'hFF;

    if (!en) begin
      state_next = ST_IDLE;
      idx_next   = 2'd0;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next  = ST_SHOW;
          idx_next    = 2'd0;
          cnt_next    = '0;
          shadow_next = value_reg;
        end
        ST_SHOW: begin
          if (cnt_reg == SHOW_LAST) begin
            state_next = ST_BLANK;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_BITS'(1);
          end
        end
        ST_BLANK: begin
          if (cnt_reg == BLANK_LAST) begin
            state_next  = ST_SHOW;
            cnt_next    = '0;
            idx_next    = idx_reg + 2'd1;
            shadow_next = value_reg;
          end else begin
            cnt_next = cnt_reg + CNT_BITS'(1);
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end

    // Outputs follow the current state, so they land one cycle after each transition.
    if (state_reg == ST_SHOW && !digit_dark) begin
      an_next  = ~(4'b0001 << idx_reg);
      seg_next = {~dp_mask[idx_reg], cur_glyph_n};
    end
  end

  assign an      = an_reg;
  assign BCDData = seg_reg;

endmodule
